// File: rtl/ula_seq_if.sv
// ula_seq_if: request/response bundle between the operand/decoder side and ula_seq.
//   master: drives start, opcode, temp1, temp2; observes busy, done, illegal,
//           result, result_hi, flag_z/c/n/v.
//   slave : the execution unit (mirror image of master).
interface ula_seq_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] temp1;
  logic [WIDTH-1:0] temp2;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output start, opcode, temp1, temp2,
    input  busy, done, illegal, result, result_hi,
    input  flag_z, flag_c, flag_n, flag_v
  );

  modport slave (
    input  start, opcode, temp1, temp2,
    output busy, done, illegal, result, result_hi,
    output flag_z, flag_c, flag_n, flag_v
  );

endinterface

// File: rtl/ula_seq.sv
// ula_seq: sequenced ALU stage. Latches opcode/temp1/temp2 on start (IDLE only),
// executes single-cycle ops in EXEC or an iterative shift-add multiply in MUL,
// then pulses done for one cycle. Result and flags hold until the next
// completed legal operation.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ula_seq_if.slave (start/opcode/temp1/temp2 in; busy, done,
//              illegal, result, result_hi, flag_z/c/n/v out, all registered)
// Build option: define ULA_MUL_EN to build the multiplier (opcode 01010);
// otherwise that opcode completes as illegal and result_hi stays 0.
module ula_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  ula_seq_if.slave  bus
);

  localparam int unsigned W1   = WIDTH + 1;
  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned SHW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_OR    = 5'b00111;
  localparam logic [4:0] OP_XOR   = 5'b01000;
  localparam logic [4:0] OP_CMP   = 5'b01001;
  localparam logic [4:0] OP_MUL   = 5'b01010;
  localparam logic [4:0] OP_SHL   = 5'b01011;
  localparam logic [4:0] OP_SHR   = 5'b01100;
  localparam logic [4:0] OP_NOT   = 5'b01101;
  localparam logic [4:0] OP_INC   = 5'b01111;
  localparam logic [4:0] OP_DEC   = 5'b10000;
  localparam logic [4:0] OP_NEG   = 5'b10001;
  localparam logic [4:0] OP_MOV   = 5'b10010;
  localparam logic [4:0] OP_PASSB = 5'b10011;

  logic [1:0]       state_q, state_d;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             z_q, c_q, n_q, v_q;
  logic             busy_q, done_q, illegal_q;

  logic             start_mul_c;

  // Extended-width arithmetic: bit WIDTH carries the carry-out or borrow.
  logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, neg_w, shl_w, shr_w;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_wr, alu_legal;

`ifdef ULA_MUL_EN
  logic [2*WIDTH-1:0] prod_q;
  logic [CNTW-1:0]    cnt_q;
  logic [WIDTH:0]     mul_sum;

  assign start_mul_c = (bus.opcode == OP_MUL);
  // One shift-add step: add multiplicand into the high half when the current
  // multiplier bit (prod_q[0]) is set, then shift the whole product right.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : W1'(0));
`else
  assign start_mul_c = 1'b0;
`endif

  assign shamt = b_q[SHW-1:0];
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign inc_w = {1'b0, a_q} + W1'(1);
  assign dec_w = {1'b0, a_q} - W1'(1);
  assign neg_w = W1'(0) - {1'b0, a_q};
  // Shift-outs land in the extra bit, so a zero shift naturally gives C=0.
  assign shl_w = {1'b0, a_q} << shamt;
  assign shr_w = {a_q, 1'b0} >> shamt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = start_mul_c ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_DONE;
`ifdef ULA_MUL_EN
      S_MUL:  if (cnt_q == CNTW'(WIDTH)) state_d = S_DONE;
`else
      S_MUL:  state_d = S_IDLE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU on the latched operands
  always_comb begin
    alu_r     = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_wr    = 1'b1;
    alu_legal = 1'b1;
    case (op_q)
      OP_ADD: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a_q[MSB] ~^ b_q[MSB]) & (add_w[MSB] ^ a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_r  = sub_w[WIDTH-1:0];
        alu_c  = sub_w[WIDTH];
        alu_v  = (a_q[MSB] ^ b_q[MSB]) & (sub_w[MSB] ^ a_q[MSB]);
        alu_wr = (op_q == OP_SUB);
      end
      OP_AND:   alu_r = a_q & b_q;
      OP_OR:    alu_r = a_q | b_q;
      OP_XOR:   alu_r = a_q ^ b_q;
      OP_SHL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      OP_NOT:   alu_r = ~a_q;
      OP_INC: begin
        alu_r = inc_w[WIDTH-1:0];
        alu_c = inc_w[WIDTH];
        alu_v = ~a_q[MSB] & inc_w[MSB];
      end
      OP_DEC: begin
        alu_r = dec_w[WIDTH-1:0];
        alu_c = dec_w[WIDTH];
        alu_v = a_q[MSB] & ~dec_w[MSB];
      end
      OP_NEG: begin
        alu_r = neg_w[WIDTH-1:0];
        alu_c = neg_w[WIDTH];
        alu_v = a_q[MSB] & neg_w[MSB];
      end
      OP_MOV:   alu_r = a_q;
      OP_PASSB: alu_r = b_q;
      // Multiply runs in its own state; it only lands here when not built.
      OP_MUL:   alu_legal = 1'b0;
      default:  alu_legal = 1'b0;
    endcase
  end

  // Operand latch, result/flag registers and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ULA_MUL_EN
      prod_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      illegal_q <= (state_q == S_EXEC) && !alu_legal;

      if (state_q == S_IDLE && bus.start) begin
        op_q <= bus.opcode;
        a_q  <= bus.temp1;
        b_q  <= bus.temp2;
`ifdef ULA_MUL_EN
        prod_q <= {{WIDTH{1'b0}}, bus.temp2};
        cnt_q  <= '0;
`endif
      end

      if (state_q == S_EXEC && alu_legal) begin
        if (alu_wr) result_q <= alu_r;
        z_q <= (alu_r == '0);
        n_q <= alu_r[MSB];
        c_q <= alu_c;
        v_q <= alu_v;
      end

`ifdef ULA_MUL_EN
      // WIDTH iterations, then one cycle to publish the product.
      if (state_q == S_MUL) begin
        if (cnt_q != CNTW'(WIDTH)) begin
          prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CNTW'(1);
        end else begin
          result_q    <= prod_q[WIDTH-1:0];
          result_hi_q <= prod_q[2*WIDTH-1:WIDTH];
          z_q         <= (prod_q == '0);
          n_q         <= 1'b0;
          c_q         <= 1'b0;
          v_q         <= 1'b0;
        end
      end
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_v    = v_q;

endmodule
